// File: rtl/bulk_flow_pkg.sv
// Shared types and default parameters for the bulk loop-back flow controller.
package bulk_flow_pkg;

   localparam int unsigned ABITS_DEF  = 11;
   localparam int unsigned MPS_HS_DEF = 512;
   localparam int unsigned MPS_FS_DEF = 64;
   localparam int unsigned SETTLE_DEF = 2;
   localparam int unsigned STATS_W    = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OUT    = 2'd1,
      ST_IN     = 2'd2,
      ST_SETTLE = 2'd3
   } state_t;

endpackage

// File: rtl/bulk_flow_ctrl_if.sv
// Block-transfer and FIFO-observation bundle for bulk_flow_ctrl.
// Statistics signals exist only when BULK_FLOW_STATS_EN is defined.
interface bulk_flow_ctrl_if
   import bulk_flow_pkg::*;
#(
   parameter int unsigned ABITS = ABITS_DEF
);

   logic             configured_i;
   logic             usb_hs_enabled_i;
   logic [ABITS:0]   level_i;
   logic             blk_start_i;
   logic             blk_dir_i;
   logic             blk_cycle_i;
   logic             wr_valid_i;
   logic             wr_ready_i;
   logic             wr_last_i;
   logic             rd_valid_i;
   logic             rd_ready_i;
   logic             rd_last_i;

   logic             blk_in_ready_o;
   logic             blk_out_ready_o;
   logic [ABITS:0]   frames_o;
   logic             xfer_busy_o;
   logic             len_err_o;
`ifdef BULK_FLOW_STATS_EN
   logic [STATS_W-1:0] pkt_in_cnt_o;
   logic [STATS_W-1:0] pkt_out_cnt_o;
   logic [STATS_W-1:0] stall_cnt_o;
`endif

   modport master (
      output configured_i, usb_hs_enabled_i, level_i,
      output blk_start_i, blk_dir_i, blk_cycle_i,
      output wr_valid_i, wr_ready_i, wr_last_i,
      output rd_valid_i, rd_ready_i, rd_last_i,
      input  blk_in_ready_o, blk_out_ready_o, frames_o, xfer_busy_o, len_err_o
`ifdef BULK_FLOW_STATS_EN
      , input pkt_in_cnt_o, pkt_out_cnt_o, stall_cnt_o
`endif
   );

   modport slave (
      input  configured_i, usb_hs_enabled_i, level_i,
      input  blk_start_i, blk_dir_i, blk_cycle_i,
      input  wr_valid_i, wr_ready_i, wr_last_i,
      input  rd_valid_i, rd_ready_i, rd_last_i,
      output blk_in_ready_o, blk_out_ready_o, frames_o, xfer_busy_o, len_err_o
`ifdef BULK_FLOW_STATS_EN
      , output pkt_in_cnt_o, pkt_out_cnt_o, stall_cnt_o
`endif
   );

endinterface

// File: rtl/bulk_frame_counter.sv
// Whole-packet count held in the bulk FIFO plus OUT packet length monitor.
module bulk_frame_counter
   import bulk_flow_pkg::*;
#(
   parameter int unsigned ABITS = ABITS_DEF
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic [ABITS:0] mps,
   input  logic           wr_beat,
   input  logic           wr_last,
   input  logic           rd_beat,
   input  logic           rd_last,
   output logic [ABITS:0] frames,
   output logic           len_err
);

   localparam int unsigned CW  = ABITS + 1;
   localparam int unsigned CW1 = CW + 1;

   logic [CW-1:0] byte_cnt;
   logic [CW:0]   byte_next_c;
   logic          over_c;
   logic          inc_c;
   logic          dec_c;

   // One extra bit so the length compare never wraps.
   assign byte_next_c = {1'b0, byte_cnt} + CW1'(1);
   assign over_c      = byte_next_c > {1'b0, mps};
   assign inc_c       = wr_beat & wr_last;
   assign dec_c       = rd_beat & rd_last;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         frames   <= '0;
         byte_cnt <= '0;
         len_err  <= 1'b0;
      end else begin
         if (inc_c && !dec_c && (frames != '1)) begin
            frames <= frames + CW'(1);
         end else if (dec_c && !inc_c && (frames != '0)) begin
            frames <= frames - CW'(1);
         end

         if (wr_beat) begin
            if (over_c) begin
               len_err <= 1'b1;
            end
            if (wr_last) begin
               byte_cnt <= '0;
            end else if (byte_cnt != '1) begin
               byte_cnt <= byte_next_c[CW-1:0];
            end
         end
      end
   end

endmodule

// File: rtl/bulk_flow_ctrl.sv
// Bulk loop-back flow controller: transfer sequencing and IN/OUT readiness.
// Optional packet/stall statistics are built when BULK_FLOW_STATS_EN is defined.
module bulk_flow_ctrl
   import bulk_flow_pkg::*;
#(
   parameter int unsigned ABITS  = ABITS_DEF,
   parameter int unsigned MPS_HS = MPS_HS_DEF,
   parameter int unsigned MPS_FS = MPS_FS_DEF,
   parameter int unsigned SETTLE = SETTLE_DEF
) (
   input  logic           clock,
   input  logic           reset_n,
   bulk_flow_ctrl_if.slave bus
);

   localparam int unsigned CW        = ABITS + 1;
   localparam int unsigned DEPTH     = 1 << ABITS;
   localparam int unsigned SW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int unsigned SETTLE_M1 = (SETTLE > 0) ? SETTLE - 1 : 0;

   state_t        state;
   logic [SW-1:0] settle_cnt;
   logic [CW-1:0] mps_c;
   logic [CW-1:0] space_c;
   logic [CW-1:0] frames;
   logic          len_err;
   logic          wr_beat_c;
   logic          rd_beat_c;
   logic          in_ready_c;
   logic          out_ready_c;

   assign mps_c     = bus.usb_hs_enabled_i ? CW'(MPS_HS) : CW'(MPS_FS);
   assign wr_beat_c = bus.wr_valid_i & bus.wr_ready_i;
   assign rd_beat_c = bus.rd_valid_i & bus.rd_ready_i;

   // Free space is zero if the reported level ever exceeds the FIFO depth.
   assign space_c     = (bus.level_i <= CW'(DEPTH)) ? (CW'(DEPTH) - bus.level_i) : '0;
   assign in_ready_c  = bus.configured_i & ((frames != '0) | (bus.level_i >= mps_c));
   assign out_ready_c = bus.configured_i & (space_c >= mps_c);

   bulk_frame_counter #(
      .ABITS (ABITS)
   ) u_frame_counter (
      .clock   (clock),
      .reset_n (reset_n),
      .mps     (mps_c),
      .wr_beat (wr_beat_c),
      .wr_last (bus.wr_last_i),
      .rd_beat (rd_beat_c),
      .rd_last (bus.rd_last_i),
      .frames  (frames),
      .len_err (len_err)
   );

   assign bus.frames_o  = frames;
   assign bus.len_err_o = len_err;

   // Transfer sequencer; readiness only refreshes while idle.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state               <= ST_IDLE;
         settle_cnt          <= '0;
         bus.blk_in_ready_o  <= 1'b0;
         bus.blk_out_ready_o <= 1'b0;
         bus.xfer_busy_o     <= 1'b0;
      end else if (!bus.configured_i) begin
         state               <= ST_IDLE;
         settle_cnt          <= '0;
         bus.blk_in_ready_o  <= 1'b0;
         bus.blk_out_ready_o <= 1'b0;
         bus.xfer_busy_o     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.blk_start_i) begin
                  state               <= bus.blk_dir_i ? ST_IN : ST_OUT;
                  bus.blk_in_ready_o  <= 1'b0;
                  bus.blk_out_ready_o <= 1'b0;
                  bus.xfer_busy_o     <= 1'b1;
               end else begin
                  bus.blk_in_ready_o  <= in_ready_c;
                  bus.blk_out_ready_o <= out_ready_c;
               end
            end
            ST_IN, ST_OUT: begin
               if (!bus.blk_cycle_i) begin
                  state      <= ST_SETTLE;
                  settle_cnt <= '0;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == SW'(SETTLE_M1)) begin
                  state           <= ST_IDLE;
                  bus.xfer_busy_o <= 1'b0;
               end else begin
                  settle_cnt <= settle_cnt + SW'(1);
               end
            end
            default: begin
               state           <= ST_IDLE;
               bus.xfer_busy_o <= 1'b0;
            end
         endcase
      end
   end

`ifdef BULK_FLOW_STATS_EN
   logic stall_c;

   assign stall_c = (state == ST_IDLE) & bus.configured_i &
                    ~bus.blk_in_ready_o & ~bus.blk_out_ready_o;

   // Packet counters wrap; the stall counter saturates.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         bus.pkt_in_cnt_o  <= '0;
         bus.pkt_out_cnt_o <= '0;
         bus.stall_cnt_o   <= '0;
      end else begin
         if (rd_beat_c && bus.rd_last_i) begin
            bus.pkt_in_cnt_o <= bus.pkt_in_cnt_o + STATS_W'(1);
         end
         if (wr_beat_c && bus.wr_last_i) begin
            bus.pkt_out_cnt_o <= bus.pkt_out_cnt_o + STATS_W'(1);
         end
         if (stall_c && (bus.stall_cnt_o != '1)) begin
            bus.stall_cnt_o <= bus.stall_cnt_o + STATS_W'(1);
         end
      end
   end
`else
   // Default build carries no statistics counters.
`endif

endmodule
